// File: rtl/mult_scan_pkg.sv
// rtl/mult_scan_pkg.sv - shared FSM state type and 7-segment constants for mult_scan_display
package mult_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MULT,
      ST_BCD,
      ST_DONE
   } state_t;

   // Active-high segments {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/mult_scan_display_if.sv
// rtl/mult_scan_display_if.sv - start/busy/done handshake and product bus of mult_scan_display
interface mult_scan_display_if #(
   parameter int FACTOR_W = 3
);
   logic [FACTOR_W-1:0]   i_factor_a;
   logic [FACTOR_W-1:0]   i_factor_b;
   logic                  i_start;
   logic                  o_busy;
   logic                  o_done;
   logic [2*FACTOR_W-1:0] o_product;

   modport master (
      output i_factor_a, i_factor_b, i_start,
      input  o_busy, o_done, o_product
   );

   modport slave (
      input  i_factor_a, i_factor_b, i_start,
      output o_busy, o_done, o_product
   );
endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD nibble to 7-segment decoder
module seg7_decoder
   import mult_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] segments
);

   always_comb begin
      segments = SEG_BLANK;
      case (bcd)
         4'd0:    segments = SEG_0;
         4'd1:    segments = SEG_1;
         4'd2:    segments = SEG_2;
         4'd3:    segments = SEG_3;
         4'd4:    segments = SEG_4;
         4'd5:    segments = SEG_5;
         4'd6:    segments = SEG_6;
         4'd7:    segments = SEG_7;
         4'd8:    segments = SEG_8;
         4'd9:    segments = SEG_9;
         default: segments = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/mult_scan_display.sv
// rtl/mult_scan_display.sv - shift-add multiplier, double-dabble BCD and scanned 7-segment display
// Optional leading-zero blanking: define MULT_SCAN_BLANK_EN.
module mult_scan_display
   import mult_scan_pkg::*;
#(
   parameter int FACTOR_W   = 3,
   parameter int NUM_DIGITS = 2,
   parameter int DIGIT_HOLD = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   mult_scan_display_if.slave    bus,
   output logic [6:0]            o_segments,
   output logic [NUM_DIGITS-1:0] o_digit_sel
);

   localparam int PW = 2 * FACTOR_W;
   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(PW + 1);
   localparam int HW = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   state_t state, state_next;

   logic [CW-1:0]       step;
   logic                last_mult, last_bcd;
   logic [PW-1:0]       mcand, acc, acc_next, bin_sh, product;
   logic [FACTOR_W-1:0] mplier;
   logic [BW-1:0]       bcd, bcd_adj, bcd_next, digits;

   assign last_mult = (step == CW'(FACTOR_W - 1));
   assign last_bcd  = (step == CW'(PW - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (bus.i_start) state_next = ST_MULT;
         ST_MULT: if (last_mult)   state_next = ST_BCD;
         ST_BCD:  if (last_bcd)    state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign acc_next = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign bcd_next = {bcd_adj[BW-2:0], bin_sh[PW-1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         step    <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         bin_sh  <= '0;
         bcd     <= '0;
         digits  <= '0;
         product <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  mcand  <= PW'(bus.i_factor_a);
                  mplier <= bus.i_factor_b;
                  acc    <= '0;
                  step   <= '0;
               end
            end
            ST_MULT: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (last_mult) begin
                  step   <= '0;
                  bin_sh <= acc_next;
                  bcd    <= '0;
               end else begin
                  step <= step + 1'b1;
               end
            end
            ST_BCD: begin
               bcd    <= bcd_next;
               bin_sh <= bin_sh << 1;
               if (last_bcd) begin
                  // Product and digits commit together so the display never shows a partial result
                  step    <= '0;
                  digits  <= bcd_next;
                  product <= acc;
               end else begin
                  step <= step + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy    = (state == ST_MULT) || (state == ST_BCD);
   assign bus.o_done    = (state == ST_DONE);
   assign bus.o_product = product;

   logic [HW-1:0] hold;
   logic [IW-1:0] idx;
   logic [6:0]    dec_seg;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= '0;
         idx  <= '0;
      end else if (hold == HW'(DIGIT_HOLD - 1)) begin
         hold <= '0;
         idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         hold <= hold + 1'b1;
      end
   end

   assign o_digit_sel = NUM_DIGITS'(1) << idx;

   seg7_decoder u_seg7 (
      .bcd      (digits[{idx, 2'b00} +: 4]),
      .segments (dec_seg)
   );

`ifdef MULT_SCAN_BLANK_EN
   // zero_run[i]: digit i and every more-significant digit are zero
   logic [NUM_DIGITS:0] zero_run;

   always_comb begin
      zero_run             = '0;
      zero_run[NUM_DIGITS] = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run[i] = zero_run[i+1] && (digits[4*i +: 4] == 4'd0);
      end
   end

   assign o_segments = ((idx != '0) && zero_run[idx]) ? SEG_BLANK : dec_seg;
`else
   assign o_segments = dec_seg;
`endif

endmodule
